map_ram_ctrl: RTL and testbench

MAP_RAM_CTRL -- requirements
Module: map_ram_ctrl

---
 rtl/map_ram_pkg.sv | 9 +
 rtl/map_ram_ctrl.sv | 84 ++++++++
 tb/tb_map_ram_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/map_ram_pkg.sv
// map_ram_pkg: shared FSM state type and reload timing for the map RAM controller.
package map_ram_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, COPY} map_ram_state_t;

    // Cycles spent before the first cell is written (ROM read priming).
    localparam int unsigned RELOAD_PRIME_CYCLES = 1;

endpackage

// File: rtl/map_ram_ctrl.sv
// map_ram_ctrl: arbitrates game-logic access to BRAM port A and restores the map from ROM.
// A reload primes the ROM for one cycle, then copies one cell per cycle.
module map_ram_ctrl
    import map_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned DATA_DEPTH  = 1023,
    parameter bit          AUTO_RELOAD = 1'b1,
    localparam int         ADDR_W      = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reload_req,
    output logic                  reload_busy,
    output logic                  reload_done,
    input  logic                  g_valid,
    input  logic                  g_we,
    input  logic [ADDR_W-1:0]     g_addr,
    input  logic [DATA_WIDTH-1:0] g_wdata,
    output logic                  g_ready,
    output logic                  g_rvalid,
    output logic [DATA_WIDTH-1:0] g_rdata,
    output logic [ADDR_W-1:0]     src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  ram_wea,
    output logic [ADDR_W-1:0]     ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    input  logic [DATA_WIDTH-1:0] ram_douta
);

    map_ram_state_t    state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              start_q, done_q, rvalid_q, oor_q;
    logic              accept, in_range, last, copying;

    assign copying  = state_q == COPY;
    assign g_ready  = (state_q == IDLE) && !reload_req;
    // Gated by reset so port A stays quiet while rst_n is low.
    assign accept   = g_valid && g_ready && rst_n;
    assign in_range = 32'(g_addr) < DATA_DEPTH;
    assign last     = 32'(wr_cnt_q) == DATA_DEPTH - 1;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        unique case (state_q)
            IDLE:    state_d = (reload_req || start_q) ? PRIME : IDLE;
            PRIME:   state_d = COPY;
            COPY: begin
                state_d  = last ? IDLE : COPY;
                wr_cnt_d = last ? '0 : wr_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_wea     = copying || (accept && g_we && in_range);
    assign ram_addra   = copying ? wr_cnt_q : (accept ? g_addr : '0);
    assign ram_dia     = copying ? src_data : (accept ? g_wdata : '0);
    assign src_addr    = copying ? wr_cnt_q + 1'b1 : '0;
    assign reload_busy = state_q != IDLE;
    assign reload_done = done_q;
    assign g_rvalid    = rvalid_q;
    assign g_rdata     = (rvalid_q && !oor_q) ? ram_douta : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_cnt_q <= '0;
            start_q  <= AUTO_RELOAD;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            start_q  <= 1'b0;
            done_q   <= copying && last;
            rvalid_q <= accept && !g_we;
            oor_q    <= !in_range;
        end
    end

endmodule

// File: tb/tb_map_ram_ctrl.sv
// tb_map_ram_ctrl: random and directed checks of map_ram_ctrl against a shadow-memory model.
// A second instance (depth 6, no auto reload) covers out-of-range addresses and reset abort.
module tb_map_ram_ctrl;
    import map_ram_pkg::*;

    localparam int DW = 4, D = 8, DB = 6, AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, reload_req, reload_busy, reload_done, g_valid, g_we, g_ready, g_rvalid, ram_wea;
    logic [AW-1:0] g_addr, src_addr, ram_addra;
    logic [DW-1:0] g_wdata, g_rdata, src_data, ram_dia, ram_douta;
    logic b_rst_n, b_reload_req, b_reload_busy, b_reload_done, b_g_valid, b_g_we, b_g_ready, b_g_rvalid, b_ram_wea;
    logic [AW-1:0] b_g_addr, b_src_addr, b_ram_addra;
    logic [DW-1:0] b_g_wdata, b_g_rdata, b_src_data, b_ram_dia, b_ram_douta;

    logic [DW-1:0] mem [8], b_mem [8], shadow [8], b_shadow [8];
    int checks = 0, failures = 0;

    map_ram_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(D), .AUTO_RELOAD(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .reload_req(reload_req), .reload_busy(reload_busy),
        .reload_done(reload_done), .g_valid(g_valid), .g_we(g_we), .g_addr(g_addr),
        .g_wdata(g_wdata), .g_ready(g_ready), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .src_addr(src_addr), .src_data(src_data), .ram_wea(ram_wea), .ram_addra(ram_addra),
        .ram_dia(ram_dia), .ram_douta(ram_douta));

    map_ram_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DB), .AUTO_RELOAD(1'b0)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .reload_req(b_reload_req), .reload_busy(b_reload_busy),
        .reload_done(b_reload_done), .g_valid(b_g_valid), .g_we(b_g_we), .g_addr(b_g_addr),
        .g_wdata(b_g_wdata), .g_ready(b_g_ready), .g_rvalid(b_g_rvalid), .g_rdata(b_g_rdata),
        .src_addr(b_src_addr), .src_data(b_src_data), .ram_wea(b_ram_wea), .ram_addra(b_ram_addra),
        .ram_dia(b_ram_dia), .ram_douta(b_ram_douta));

    // BRAM port A models (read-first, 1-cycle latency) and ROM models (cell i = i+3)
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dia;
        ram_douta <= mem[ram_addra];
        src_data  <= DW'(32'(src_addr) + 3);
        if (b_ram_wea) b_mem[b_ram_addra] <= b_ram_dia;
        b_ram_douta <= b_mem[b_ram_addra];
        b_src_data  <= DW'(32'(b_src_addr) + 3);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic watch(input int n, input int pulse_at, output int busy, output int dones);
        busy = 0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reload_req = (i == pulse_at);
            busy += int'(reload_busy);
            dones += int'(reload_done);
        end
        reload_req = 1'b0;
        for (int i = 0; i < D; i++) shadow[i] = DW'(i + 3);
    endtask

    task automatic gop(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        g_valid = 1'b1; g_we = we; g_addr = a; g_wdata = d;
        #1 chk("gop_ready", g_ready, 1);
        chk("gop_wea", ram_wea, we);
        @(negedge clk);
        g_valid = 1'b0;
        chk("gop_rvalid", g_rvalid, !we);
        if (!we) chk("gop_rdata", g_rdata, shadow[a]);
        else shadow[a] = d;
    endtask

    task automatic bop(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        b_g_valid = 1'b1; b_g_we = we; b_g_addr = a; b_g_wdata = d;
        #1 chk("bop_ready", b_g_ready, 1);
        chk("bop_wea", b_ram_wea, we && a < DB);
        chk("bop_addra", b_ram_addra, a);
        @(negedge clk);
        b_g_valid = 1'b0;
        chk("bop_rvalid", b_g_rvalid, !we);
        if (!we) chk("bop_rdata", b_g_rdata, a < DB ? b_shadow[a] : 0);
        else if (a < DB) b_shadow[a] = d;
    endtask

    initial begin
        int busy, dones, bbusy, bdones, got, k;
        logic exp_rv, we;
        logic [DW-1:0] exp_rd, d;
        logic [AW-1:0] a;
        for (int i = 0; i < 8; i++) begin mem[i] = '0; b_mem[i] = 4'hF; end
        rst_n = 0; b_rst_n = 0; reload_req = 0; b_reload_req = 0;
        g_valid = 0; g_we = 0; g_addr = '0; g_wdata = '0;
        b_g_valid = 0; b_g_we = 0; b_g_addr = '0; b_g_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", reload_busy, 0);
        chk("rst_done", reload_done, 0);
        chk("rst_rvalid", g_rvalid, 0);
        chk("rst_rdata", g_rdata, 0);
        chk("rst_wea", ram_wea, 0);
        chk("rst_addra", ram_addra, 0);
        chk("rst_src_addr", src_addr, 0);

        // auto reload on release; depth-6 instance must stay idle
        rst_n = 1; b_rst_n = 1;
        busy = 0; dones = 0; bbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk("auto_first_busy", reload_busy, 1);
            busy += int'(reload_busy);
            dones += int'(reload_done);
            bbusy += int'(b_reload_busy);
        end
        chk("auto_busy_cycles", busy, D + RELOAD_PRIME_CYCLES);
        chk("auto_done_pulses", dones, 1);
        chk("noauto_busy", bbusy, 0);
        for (int i = 0; i < D; i++) begin
            chk($sformatf("ram_init_%0d", i), mem[i], i + 3);
            shadow[i] = DW'(i + 3);
        end

        gop(1'b1, 3'd5, 4'hA);
        gop(1'b0, 3'd5, 4'h0);

        // random back-to-back traffic against the shadow model
        exp_rv = 0; exp_rd = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            chk("rnd_rvalid", g_rvalid, exp_rv);
            if (exp_rv) chk("rnd_rdata", g_rdata, exp_rd);
            we = 1'($urandom_range(0, 1)); a = AW'($urandom_range(0, 7)); d = DW'($urandom);
            g_valid = 1; g_we = we; g_addr = a; g_wdata = d;
            #1 chk("rnd_ready", g_ready, 1);
            chk("rnd_wea", ram_wea, we);
            chk("rnd_addra", ram_addra, a);
            exp_rv = !we; exp_rd = shadow[a];
            if (we) shadow[a] = d;
        end
        @(negedge clk);
        g_valid = 0;
        chk("rnd_last_rvalid", g_rvalid, exp_rv);
        if (exp_rv) chk("rnd_last_rdata", g_rdata, exp_rd);

        // reload_req and a read in the same idle cycle
        @(negedge clk);
        reload_req = 1; g_valid = 1; g_we = 0; g_addr = 3'd2;
        #1 chk("collide_ready", g_ready, 0);
        chk("collide_wea", ram_wea, 0);
        got = -1; busy = 0;
        for (int i = 0; i < 30 && got < 0; i++) begin
            @(negedge clk);
            reload_req = 0;
            busy += int'(reload_busy);
            if (g_ready) got = i;
        end
        chk("collide_accept_cycle", got, D + 1);
        chk("collide_busy", busy, D + 1);
        chk("collide_addra", ram_addra, 2);
        @(negedge clk);
        g_valid = 0;
        chk("collide_rvalid", g_rvalid, 1);
        chk("collide_rdata", g_rdata, 5);
        for (int i = 0; i < D; i++) shadow[i] = DW'(i + 3);

        // reload_req pulsed mid-COPY is ignored
        gop(1'b1, 3'd7, 4'h1);
        @(negedge clk);
        reload_req = 1;
        watch(24, 4, busy, dones);
        chk("ignore_busy", busy, 9);
        chk("ignore_done", dones, 1);
        chk("ignore_ram7", mem[7], 10);
        gop(1'b0, 3'd7, 4'h0);

        // reset mid-COPY on the AUTO_RELOAD=0 instance
        @(negedge clk); b_reload_req = 1;
        @(negedge clk); b_reload_req = 0;
        k = 0;
        while (!(b_reload_busy && b_ram_wea && b_ram_addra == 3'd4) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("abort_copy4_at", k, 5);
        b_rst_n = 0;
        #1 chk("abort_busy", b_reload_busy, 0);
        chk("abort_done", b_reload_done, 0);
        chk("abort_rvalid", b_g_rvalid, 0);
        chk("abort_rdata", b_g_rdata, 0);
        chk("abort_wea", b_ram_wea, 0);
        chk("abort_addra", b_ram_addra, 0);
        chk("abort_src_addr", b_src_addr, 0);
        @(negedge clk); b_rst_n = 1;
        bbusy = 0; bdones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bbusy += int'(b_reload_busy);
            bdones += int'(b_reload_done);
        end
        chk("abort_stay_idle", bbusy, 0);
        chk("abort_no_done", bdones, 0);

        // full reload of the non-power-of-two depth
        @(negedge clk); b_reload_req = 1;
        bbusy = 0; bdones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b_reload_req = 0;
            bbusy += int'(b_reload_busy);
            bdones += int'(b_reload_done);
        end
        chk("b_busy_cycles", bbusy, DB + 1);
        chk("b_done_pulses", bdones, 1);
        for (int i = 0; i < DB; i++) begin
            chk($sformatf("b_ram_%0d", i), b_mem[i], i + 3);
            b_shadow[i] = DW'(i + 3);
        end
        chk("b_ram_6_untouched", b_mem[6], 4'hF);

        bop(1'b0, 3'd5, 4'h0);
        bop(1'b0, 3'd7, 4'h0);
        bop(1'b1, 3'd7, 4'hC);
        bop(1'b0, 3'd6, 4'h0);
        bop(1'b1, 3'd2, 4'h1);
        bop(1'b0, 3'd2, 4'h0);
        chk("b_ram_7_untouched", b_mem[7], 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
